button_reader: RTL and testbench
================================

// Module: button_reader
// PURPOSE
//  Memory-mapped input side of the game I/O: captures the four colour push-buttons
//  (red/blue/green/yellow) for the processor, mirroring the LED-flash store path.
//  Raw buttons are synchronised, debounced, edge-detected and queued as press events.
//  The processor polls them with lw from BTN_ADDR; each qualifying read pops one event.
//  Sits in the wrapper beside RAM/LFSR; the wrapper muxes rd_data onto q_dmem at BTN_ADDR.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable cycles before debounced level changes (>=2)
//  FIFO_DEPTH       4       event queue depth, power of 2, >=2
//  BTN_ADDR         12'd7   dmem word address decoded for reads
// PORTS
//  clock     in   1   system clock, all state on posedge
//  reset     in   1   synchronous, active-high; clears all state
//  btn_in    in   4   raw async buttons, active-high; [0]=red [1]=blue [2]=green [3]=yellow
//  mem_addr  in   12  dmem address from processor (address_dmem[11:0])
//  mem_rd    in   1   wrapper-decoded load strobe, 1 cycle per lw
//  rd_data   out  32  read word (comb. from state); layout below
//  evt_pend  out  1   queue non-empty (debug/LED)
// BEHAVIOUR
//  - rd_data: [0]=valid(queue non-empty) [2:1]=colour code (00 red,01 blue,10 green,
//    11 yellow; same encoding as LED store) [3]=overflow sticky [4]=release flag; rest 0.
//    Empty queue: [2:0]=0, [4]=0, [3] still reflects overflow.
//  - Reset (sync, active-high): sync FFs, debounced levels, counters, pending bits,
//    FIFO pointers/count, overflow all 0 -> rd_data=0, evt_pend=0 next cycle.
//    Reset mid-debounce or with events queued discards everything; a button held
//    through reset yields one press event after DEBOUNCE_CYCLES once reset drops.
//  - Sync: 2-FF synchroniser per button.
//  - Debounce per button: counter clears when sync level == debounced level; else
//    increments; when it reaches DEBOUNCE_CYCLES-1 debounced level takes sync level,
//    counter clears. Glitch shorter than DEBOUNCE_CYCLES never changes the level.
//  - Edge: debounced 0->1 sets pending[i]. Pending bits survive until enqueued.
//  - Arbiter: each cycle, if any pending and queue not full (or popped this cycle),
//    enqueue lowest set index i, clear pending[i]. One push per cycle max.
//  - Latency: raw edge stable -> valid in rd_data in DEBOUNCE_CYCLES+4 cycles (queue
//    empty, no competing pending). Never earlier than DEBOUNCE_CYCLES+2.
//  - Pop: posedge with mem_rd=1 and mem_addr==BTN_ADDR: if non-empty, advance head;
//    rd_data sampled by processor is pre-pop head. Pop also clears overflow (after the
//    read returned it). Reads to other addresses ignored; read while empty no-op.
//  - Push+pop same cycle: both occur, count unchanged; allowed when full.
//  - Full, no pop: if a pending event is selected and queue full -> event dropped,
//    pending[i] cleared, overflow<=1. Overflow set and clear same cycle -> set wins.
//  - Pointers wrap mod FIFO_DEPTH; count 0..FIFO_DEPTH; evt_pend=(count!=0).
// CONFIGURATION
//  BUTTON_READER_RELEASE_EN defined: debounced 1->0 also sets a release-pending bit;
//  release events arbitrate after all press pendings (same lowest-index rule) and
//  are queued with rd_data[4]=1. Undefined: releases ignored, bit[4] tied 0, no
//  release-pending logic synthesised.
// TESTING  (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
//  1 btn_in=0100 held 20 cyc -> rd_data=32'h5 at cycle 8 after edge; lw@7 -> 5 read,
//    then rd_data=0, evt_pend=0.
//  2 btn_in[0] pulse 2 cyc -> no event ever; rd_data stays 0.
//  3 btn_in=1011 rising same cycle -> queue order red,blue,yellow: reads 1,3,7.
//  4 Five presses, no reads -> queue 4 entries, 5th dropped, bit3=1; first lw returns
//    bit3=1 and oldest code; next read bit3=0.
//  5 Queue full + lw@7 same cycle as new press -> both applied, count stays 4, no overflow.
//  6 Event queued, reset 1 cycle while btn held -> rd_data=0; one press after debounce;
//    RELEASE_EN: drop btn -> release event rd_data=32'h11 (red).

Source files
------------

// File: rtl/button_reader.sv
// Memory-mapped colour-button reader: sync, debounce, press detection and an event FIFO polled by lw.
// Optional macro BUTTON_READER_RELEASE_EN also queues release events, flagged in rd_data[4].
module button_reader #(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [11:0] BTN_ADDR        = 12'd7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  btn_in,
    input  logic [11:0] mem_addr,
    input  logic        mem_rd,
    output logic [31:0] rd_data,
    output logic        evt_pend
);

    localparam int NUM_BTN = 4;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
`ifdef BUTTON_READER_RELEASE_EN
    localparam int ENTRY_W = 3;
`else
    localparam int ENTRY_W = 2;
`endif

    // Two-flop synchroniser on the raw, asynchronous button pins.
    logic [NUM_BTN-1:0] sync1_reg;
    logic [NUM_BTN-1:0] sync2_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_in;
            sync2_reg <= sync1_reg;
        end
    end

    logic [NUM_BTN-1:0] deb_level;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic             level_reg;

            // The level only follows the input after a full run of disagreeing samples.
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (sync2_reg[gi] == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_reg   <= '0;
                    level_reg <= sync2_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign deb_level[gi] = level_reg;
        end
    endgenerate

    logic [NUM_BTN-1:0] deb_prev_reg;
    logic [NUM_BTN-1:0] press_pend_reg;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] sel_onehot;
    logic [NUM_BTN-1:0] press_clr;
    logic               sel_valid;
    logic               sel_rel;
    logic [1:0]         sel_idx;

    assign rise = deb_level & ~deb_prev_reg;

`ifdef BUTTON_READER_RELEASE_EN
    logic [NUM_BTN-1:0] rel_pend_reg;
    logic [NUM_BTN-1:0] fall;
    logic [NUM_BTN-1:0] rel_clr;

    assign fall    = ~deb_level & deb_prev_reg;
    assign rel_clr = (sel_valid && sel_rel) ? sel_onehot : '0;
`endif

    // Lowest index wins; release events only get a slot when no press is waiting.
    always_comb begin
        sel_valid = 1'b0;
        sel_rel   = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press_pend_reg[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 2'(i);
            end
        end
`ifdef BUTTON_READER_RELEASE_EN
        if (!sel_valid) begin
            for (int i = NUM_BTN - 1; i >= 0; i--) begin
                if (rel_pend_reg[i]) begin
                    sel_valid = 1'b1;
                    sel_rel   = 1'b1;
                    sel_idx   = 2'(i);
                end
            end
        end
`endif
    end

    assign sel_onehot = {{(NUM_BTN - 1){1'b0}}, 1'b1} << sel_idx;
    assign press_clr  = (sel_valid && !sel_rel) ? sel_onehot : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            deb_prev_reg   <= '0;
            press_pend_reg <= '0;
        end else begin
            deb_prev_reg   <= deb_level;
            press_pend_reg <= (press_pend_reg & ~press_clr) | rise;
        end
    end

`ifdef BUTTON_READER_RELEASE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rel_pend_reg <= '0;
        end else begin
            rel_pend_reg <= (rel_pend_reg & ~rel_clr) | fall;
        end
    end
`endif

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               ovf_reg;
    logic               fifo_valid;
    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;

    assign fifo_valid = (count_reg != '0);
    assign fifo_full  = (count_reg == FIFO_FULL);
    assign pop        = mem_rd && (mem_addr == BTN_ADDR) && fifo_valid;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign push       = sel_valid && (!fifo_full || pop);
    assign drop       = sel_valid && fifo_full && !pop;

`ifdef BUTTON_READER_RELEASE_EN
    assign wr_entry = {sel_rel, sel_idx};
`else
    assign wr_entry = sel_idx;
`endif

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wr_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // The processor has already seen the sticky bit by the time its read pops.
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (pop) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign head = fifo_mem[rd_ptr_reg];

    always_comb begin
        rd_data    = '0;
        rd_data[3] = ovf_reg;
        if (fifo_valid) begin
            rd_data[0]   = 1'b1;
            rd_data[2:1] = head[1:0];
`ifdef BUTTON_READER_RELEASE_EN
            rd_data[4]   = head[2];
`endif
        end
    end

    assign evt_pend = fifo_valid;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: queue-based reference model checked every cycle, directed
// scenarios with hand-computed values, then a randomized soak with occasional resets.
module tb_button_reader;

    localparam int D = 4;
    localparam int F = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  btn_in = 4'h0;
    logic [11:0] mem_addr = 12'h0;
    logic        mem_rd = 1'b0;
    logic [31:0] rd_data;
    logic        evt_pend;

    button_reader #(
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH(F),
        .BTN_ADDR(12'd7)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_in(btn_in),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .rd_data(rd_data),
        .evt_pend(evt_pend)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: raw samples reach the debouncer two clocks late; a level flips
    // once the last D samples all disagree with it; events live in a plain queue.
    bit [3:0] raw_q[$];
    bit       sh[4][$];
    bit [3:0] m_deb, m_debprev, m_pend;
`ifdef BUTTON_READER_RELEASE_EN
    bit [3:0] m_rpend;
`endif
    bit [2:0] m_fifo[$];
    bit       m_ovf;

    task automatic model_clear();
        raw_q.delete();
        raw_q.push_back(4'h0);
        raw_q.push_back(4'h0);
        for (int i = 0; i < 4; i++) sh[i].delete();
        m_deb = 4'h0;
        m_debprev = 4'h0;
        m_pend = 4'h0;
`ifdef BUTTON_READER_RELEASE_EN
        m_rpend = 4'h0;
`endif
        m_fifo.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_step();
        bit [3:0] s, rise;
        bit popq, selrel, all_diff;
        int sel;
`ifdef BUTTON_READER_RELEASE_EN
        bit [3:0] fall;
`endif
        if (reset) begin
            model_clear();
            return;
        end
        s = raw_q.pop_front();
        raw_q.push_back(btn_in);
        rise = m_deb & ~m_debprev;
`ifdef BUTTON_READER_RELEASE_EN
        fall = ~m_deb & m_debprev;
`endif
        m_debprev = m_deb;
        popq = mem_rd && (mem_addr == 12'd7) && (m_fifo.size() != 0);
        sel = -1;
        selrel = 1'b0;
        for (int i = 0; i < 4; i++) if (sel < 0 && m_pend[i]) sel = i;
`ifdef BUTTON_READER_RELEASE_EN
        for (int i = 0; i < 4; i++) begin
            if (sel < 0 && m_rpend[i]) begin
                sel = i;
                selrel = 1'b1;
            end
        end
`endif
        if (popq) begin
            void'(m_fifo.pop_front());
            m_ovf = 1'b0;
        end
        if (sel >= 0) begin
            if (m_fifo.size() < F) m_fifo.push_back({selrel, sel[1:0]});
            else m_ovf = 1'b1;
`ifdef BUTTON_READER_RELEASE_EN
            if (selrel) m_rpend[sel] = 1'b0;
            else
`endif
            m_pend[sel] = 1'b0;
        end
        m_pend = m_pend | rise;
`ifdef BUTTON_READER_RELEASE_EN
        m_rpend = m_rpend | fall;
`endif
        for (int i = 0; i < 4; i++) begin
            sh[i].push_back(s[i]);
            if (sh[i].size() > D) void'(sh[i].pop_front());
            if (sh[i].size() == D) begin
                all_diff = 1'b1;
                for (int k = 0; k < sh[i].size(); k++) if (sh[i][k] == m_deb[i]) all_diff = 1'b0;
                if (all_diff) m_deb[i] = ~m_deb[i];
            end
        end
    endtask

    function automatic logic [31:0] model_rd();
        logic [31:0] v;
        v = '0;
        v[3] = m_ovf;
        if (m_fifo.size() != 0) begin
            v[0]   = 1'b1;
            v[2:1] = m_fifo[0][1:0];
            v[4]   = m_fifo[0][2];
        end
        return v;
    endfunction

    initial begin
        model_clear();
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check("rd_data_model", rd_data, model_rd());
                check("evt_pend_model", {31'b0, evt_pend}, {31'b0, (m_fifo.size() != 0)});
            end
        end
    end

    // Drive a one-cycle lw at BTN_ADDR; v is the word the processor samples (pre-pop head).
    task automatic do_read(output logic [31:0] v);
        mem_rd = 1'b1;
        mem_addr = 12'd7;
        v = rd_data;
        @(negedge clock);
        mem_rd = 1'b0;
        mem_addr = 12'd0;
        $display("read @7 -> %h", v);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [31:0] v;
        int hold;
        wait_cyc(3);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_evt_pend", {31'b0, evt_pend}, 32'h0);
        reset = 1'b0;
        chk_en = 1'b1;

`ifndef BUTTON_READER_RELEASE_EN
        // Green held: valid appears exactly D+4 clocks after the raw edge.
        btn_in = 4'b0100;
        wait_cyc(7);
        check("t1_before_latency", rd_data, 32'h0);
        wait_cyc(1);
        check("t1_latency", rd_data, 32'h5);
        wait_cyc(12);
        do_read(v);
        check("t1_read", v, 32'h5);
        check("t1_after_pop", rd_data, 32'h0);
        check("t1_evt_pend", {31'b0, evt_pend}, 32'h0);
        btn_in = 4'b0000;
        wait_cyc(12);

        // Two-cycle glitch on red never registers.
        btn_in = 4'b0001;
        wait_cyc(2);
        btn_in = 4'b0000;
        wait_cyc(15);
        check("t2_glitch", rd_data, 32'h0);

        // Simultaneous red/blue/yellow queue in index order.
        btn_in = 4'b1011;
        wait_cyc(14);
        btn_in = 4'b0000;
        wait_cyc(12);
        do_read(v); check("t3_red", v, 32'h1);
        do_read(v); check("t3_blue", v, 32'h3);
        do_read(v); check("t3_yellow", v, 32'h7);
        check("t3_empty", rd_data, 32'h0);

        // Five presses with no reads: fifth dropped, overflow seen once.
        btn_in = 4'b1111;
        wait_cyc(14);
        btn_in = 4'b0000;
        wait_cyc(12);
        btn_in = 4'b0001;
        wait_cyc(12);
        btn_in = 4'b0000;
        wait_cyc(12);
        do_read(v); check("t4_ovf_red", v, 32'h9);
        do_read(v); check("t4_blue_noovf", v, 32'h3);
        do_read(v); check("t4_green", v, 32'h5);
        do_read(v); check("t4_yellow", v, 32'h7);
        check("t4_empty", rd_data, 32'h0);

        // Full queue: pop and push land on the same edge, no overflow.
        btn_in = 4'b1111;
        wait_cyc(14);
        btn_in = 4'b0000;
        wait_cyc(12);
        check("t5_full_head", rd_data, 32'h1);
        btn_in = 4'b0001;
        wait_cyc(7);
        do_read(v); check("t5_pop_red", v, 32'h1);
        check("t5_head_blue", rd_data, 32'h3);
        btn_in = 4'b0000;
        wait_cyc(12);
        do_read(v); check("t5_blue", v, 32'h3);
        do_read(v); check("t5_green", v, 32'h5);
        do_read(v); check("t5_yellow", v, 32'h7);
        do_read(v); check("t5_new_red", v, 32'h1);
        check("t5_empty", rd_data, 32'h0);
`endif

        // Reset with an event queued and red still held.
        btn_in = 4'b0001;
        wait_cyc(12);
        check("t6_queued", rd_data, 32'h1);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check("t6_cleared", rd_data, 32'h0);
        check("t6_cleared_pend", {31'b0, evt_pend}, 32'h0);
        wait_cyc(7);
        check("t6_before_latency", rd_data, 32'h0);
        wait_cyc(1);
        check("t6_repress", rd_data, 32'h1);
        do_read(v); check("t6_read", v, 32'h1);
        btn_in = 4'b0000;
        wait_cyc(12);
`ifdef BUTTON_READER_RELEASE_EN
        do_read(v); check("t6_release", v, 32'h11);
`else
        check("t6_no_release", rd_data, 32'h0);
`endif

        // Randomized soak against the model.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                btn_in = 4'($urandom);
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            mem_rd = ($urandom_range(0, 5) == 0);
            mem_addr = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'd7;
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clock);
        end
        mem_rd = 1'b0;
        reset = 1'b0;
        wait_cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
